lc3b_mem_bridge: RTL and testbench

- Sits directly downstream of the LC-3b multicycle control unit and datapath, on the memory side.
- Consumes the CPU's level-held mem_read/mem_write requests (address, write data, byte mask) and converts each one into a single req/ack transaction on the physical memory port.
- Returns read data and a single-cycle mem_resp pulse to the control FSM.
- Adds a watchdog timeout so a dead memory cannot hang the CPU.

---
 rtl/lc3b_mem_bridge.sv | 138 +++++++++++++
 tb/tb_lc3b_mem_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_bridge.sv
// lc3b_mem_bridge: turns the LC-3b control unit's level-held mem_read /
// mem_write requests into one req/ack handshake on the physical memory
// port. It returns registered read data with a one-cycle mem_resp pulse.
// A watchdog ends a transaction when memory never acknowledges, so a dead
// memory cannot stall the CPU forever.
module lc3b_mem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        phys_req,
  output logic        phys_we,
  output logic [15:0] phys_addr,
  output logic [15:0] phys_wdata,
  output logic [1:0]  phys_be,
  input  logic        phys_ack,
  input  logic [15:0] phys_rdata,
  output logic        timeout_err,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

  // Counter value seen on the last REQ cycle before the watchdog fires.
  // It is meaningless when TIMEOUT is 0, because the watchdog is then disabled.
  localparam logic [CNT_W-1:0] CntLast =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             perr_q, perr_d;

  // State and datapath registers; reset drops phys_req at once and abandons any transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: accept a request in IDLE, wait for ack or timeout in REQ, pulse in RESP
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    perr_d  = perr_q;

    case (state_q)
      StIdle: begin
        if (mem_write || mem_read) begin
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_write ? mem_byte_enable : 2'b11;
          we_d    = mem_write;
          cnt_d   = '0;
          state_d = StReq;
          if (mem_read && mem_write) begin
            perr_d = 1'b1;
          end
        end
      end

      StReq: begin
        if (phys_ack) begin
          if (!we_q) begin
            rdata_d = phys_rdata;
          end
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          rdata_d = 16'h0000;
          terr_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign phys_req    = (state_q == StReq);
  assign mem_resp    = (state_q == StResp);
  assign phys_we     = we_q;
  assign phys_addr   = addr_q;
  assign phys_wdata  = wdata_q;
  assign phys_be     = be_q;
  assign mem_rdata   = rdata_q;
  assign timeout_err = terr_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// tb_lc3b_mem_bridge: directed-vector bench for lc3b_mem_bridge with TIMEOUT=4.
// Inputs change 1 ns after each rising edge, and outputs are sampled at that same point.
module tb_lc3b_mem_bridge;

  logic        clk;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        phys_req;
  logic        phys_we;
  logic [15:0] phys_addr;
  logic [15:0] phys_wdata;
  logic [1:0]  phys_be;
  logic        phys_ack;
  logic [15:0] phys_rdata;
  logic        timeout_err;
  logic        proto_err;

  int compared;
  int mismatched;

  lc3b_mem_bridge #(
    .TIMEOUT(4),
    .CNT_W  (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .phys_req       (phys_req),
    .phys_we        (phys_we),
    .phys_addr      (phys_addr),
    .phys_wdata     (phys_wdata),
    .phys_be        (phys_be),
    .phys_ack       (phys_ack),
    .phys_rdata     (phys_rdata),
    .timeout_err    (timeout_err),
    .proto_err      (proto_err)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up the CPU-side request lines
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wd, input logic [1:0] be);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
  endtask

  // Expected per-cycle phys_req / mem_resp for the back-to-back read
  logic [6:0] b2bReq  = 7'b0001001;
  logic [6:0] b2bResp = 7'b0010010;
  int respPulses;

  // Directed test sequence
  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    phys_ack   = 1'b0;
    phys_rdata = 16'h0000;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);

    // Values while reset is held
    #12;
    checkOutput("rst_req", phys_req, 0);
    checkOutput("rst_resp", mem_resp, 0);
    checkOutput("rst_rdata", mem_rdata, 0);
    checkOutput("rst_be", phys_be, 0);
    checkOutput("rst_addr", phys_addr, 0);
    checkOutput("rst_errs", {timeout_err, proto_err}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Zero-wait read
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00);
    tick();
    checkOutput("rd_req", phys_req, 1);
    checkOutput("rd_addr", phys_addr, 16'h0040);
    checkOutput("rd_be", phys_be, 2'b11);
    checkOutput("rd_we", phys_we, 0);
    checkOutput("rd_resp_early", mem_resp, 0);
    phys_ack   = 1'b1;
    phys_rdata = 16'hBEEF;
    tick();
    checkOutput("rd_resp", mem_resp, 1);
    checkOutput("rd_req_off", phys_req, 0);
    checkOutput("rd_data", mem_rdata, 16'hBEEF);
    mem_read = 1'b0;
    phys_ack = 1'b0;
    tick();
    checkOutput("rd_resp_end", mem_resp, 0);
    checkOutput("rd_data_hold", mem_rdata, 16'hBEEF);

    // Byte write with three wait states; the ack lands on the watchdog's last cycle
    applyStimulus(1'b0, 1'b1, 16'h1235, 16'hAB00, 2'b10);
    phys_rdata = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("wr_req%0d", i), phys_req, 1);
      checkOutput($sformatf("wr_noresp%0d", i), mem_resp, 0);
      if (i == 3) phys_ack = 1'b1;
    end
    tick();
    checkOutput("wr_resp", mem_resp, 1);
    checkOutput("wr_be", phys_be, 2'b10);
    checkOutput("wr_wdata", phys_wdata, 16'hAB00);
    checkOutput("wr_addr", phys_addr, 16'h1235);
    checkOutput("wr_we", phys_we, 1);
    checkOutput("wr_rdata_keep", mem_rdata, 16'hBEEF);
    checkOutput("wr_no_tmo", timeout_err, 0);
    mem_write = 1'b0;
    phys_ack  = 1'b0;
    tick();

    // Timeout: memory never acknowledges
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00);
    phys_rdata = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("tmo_req%0d", i), phys_req, 1);
      checkOutput($sformatf("tmo_noresp%0d", i), mem_resp, 0);
    end
    tick();
    checkOutput("tmo_resp", mem_resp, 1);
    checkOutput("tmo_rdata", mem_rdata, 16'h0000);
    checkOutput("tmo_err", timeout_err, 1);
    mem_read = 1'b0;
    phys_ack = 1'b1;
    tick();
    checkOutput("late_ack_resp", mem_resp, 0);
    checkOutput("late_ack_req", phys_req, 0);
    tick();
    checkOutput("late_ack_resp2", mem_resp, 0);
    checkOutput("tmo_sticky", timeout_err, 1);
    phys_ack = 1'b0;

    // Read and write together: the write wins and proto_err is set
    applyStimulus(1'b1, 1'b1, 16'h0300, 16'h1234, 2'b01);
    tick();
    checkOutput("cf_we", phys_we, 1);
    checkOutput("cf_be", phys_be, 2'b01);
    checkOutput("cf_perr", proto_err, 1);
    phys_ack = 1'b1;
    tick();
    checkOutput("cf_resp", mem_resp, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    phys_ack = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'h0000, 2'b00);
    phys_rdata = 16'hCAFE;
    tick();
    checkOutput("cf2_we", phys_we, 0);
    phys_ack = 1'b1;
    tick();
    checkOutput("cf2_data", mem_rdata, 16'hCAFE);
    checkOutput("cf2_perr", proto_err, 1);
    mem_read = 1'b0;
    phys_ack = 1'b0;
    tick();

    // Reset asserted between edges while in REQ
    applyStimulus(1'b1, 1'b0, 16'h0500, 16'h0000, 2'b00);
    tick();
    checkOutput("mr_req", phys_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mr_req_drop", phys_req, 0);
    checkOutput("mr_addr", phys_addr, 0);
    checkOutput("mr_rdata", mem_rdata, 0);
    checkOutput("mr_errs", {timeout_err, proto_err}, 0);
    mem_read = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("mr_idle_req%0d", i), phys_req, 0);
      checkOutput($sformatf("mr_idle_resp%0d", i), mem_resp, 0);
    end

    // Back-to-back: request held through RESP, ack permanently high
    applyStimulus(1'b1, 1'b0, 16'h0600, 16'h0000, 2'b00);
    phys_rdata = 16'h7777;
    phys_ack   = 1'b1;
    respPulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("b2b_req%0d", i), phys_req, b2bReq[i]);
      checkOutput($sformatf("b2b_resp%0d", i), mem_resp, b2bResp[i]);
      if (mem_resp) respPulses++;
      if (i == 4) mem_read = 1'b0;
    end
    checkOutput("b2b_pulses", respPulses, 2);
    checkOutput("b2b_data", mem_rdata, 16'h7777);
    phys_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
